// File: rtl/spi_adc_sequencer.sv
// SPI ADC read sequencer. Each transaction drives chip select low, waits a setup
// delay, sends one command byte and, if any read bytes were requested, waits a
// T6 turnaround delay. It then clocks in up to three read bytes, waits a CS hold
// delay, and finally presents the assembled read word for one cycle.
// All outputs are registered; they are computed from the next state so that
// each output lines up with the state it belongs to.
module spi_adc_sequencer #(
    parameter logic [7:0] TX_FILL = 8'h00
) (
    input  logic        clock_i,
    input  logic        reset_n_i,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [7:0]  cmd_i,
    input  logic [1:0]  nrx_i,
    output logic        busy_o,
    output logic        cs_n_o,
    output logic        byte_start_o,
    output logic [7:0]  byte_tx_o,
    input  logic        byte_done_i,
    input  logic [7:0]  byte_rx_i,
    output logic        delay_en_o,
    input  logic        delay_done_i,
    output logic [23:0] data_o,
    output logic        data_valid_o
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        CS_SETUP  = 4'd1,
        SEND_CMD  = 4'd2,
        WAIT_CMD  = 4'd3,
        T6        = 4'd4,
        READ_BYTE = 4'd5,
        WAIT_BYTE = 4'd6,
        CS_HOLD   = 4'd7,
        DONE      = 4'd8
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [7:0]  cmd_r;
    logic [7:0]  cmd_nxt_s;
    logic [1:0]  nrx_r;
    logic [1:0]  nrx_nxt_s;
    logic [1:0]  cnt_r;
    logic [1:0]  cnt_nxt_s;
    logic [1:0]  cnt_inc_s;
    logic [23:0] data_r;
    logic [23:0] data_nxt_s;

    logic        busy_nxt_s;
    logic        cs_n_nxt_s;
    logic        byte_start_nxt_s;
    logic [7:0]  byte_tx_nxt_s;
    logic        delay_en_nxt_s;
    logic        data_valid_nxt_s;

    assign cnt_inc_s = cnt_r + 2'd1;

    // Next-state and datapath: abort wins over every transition, start is only seen in IDLE
    always_comb begin
        state_nxt_s = state_r;
        cmd_nxt_s   = cmd_r;
        nrx_nxt_s   = nrx_r;
        cnt_nxt_s   = cnt_r;
        data_nxt_s  = data_r;
        if ((state_r != IDLE) && abort_i) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_i) begin
                        state_nxt_s = CS_SETUP;
                        cmd_nxt_s   = cmd_i;
                        nrx_nxt_s   = nrx_i;
                        cnt_nxt_s   = 2'd0;
                        data_nxt_s  = 24'd0;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                CS_SETUP: begin
                    if (delay_done_i) begin
                        state_nxt_s = SEND_CMD;
                    end else begin
                        state_nxt_s = CS_SETUP;
                    end
                end
                SEND_CMD: state_nxt_s = WAIT_CMD;
                WAIT_CMD: begin
                    if (byte_done_i) begin
                        if (nrx_r == 2'd0) begin
                            state_nxt_s = CS_HOLD;
                        end else begin
                            state_nxt_s = T6;
                        end
                    end else begin
                        state_nxt_s = WAIT_CMD;
                    end
                end
                T6: begin
                    if (delay_done_i) begin
                        state_nxt_s = READ_BYTE;
                    end else begin
                        state_nxt_s = T6;
                    end
                end
                READ_BYTE: state_nxt_s = WAIT_BYTE;
                WAIT_BYTE: begin
                    if (byte_done_i) begin
                        data_nxt_s = {data_r[15:0], byte_rx_i};
                        cnt_nxt_s  = cnt_inc_s;
                        if (cnt_inc_s == nrx_r) begin
                            state_nxt_s = CS_HOLD;
                        end else begin
                            state_nxt_s = READ_BYTE;
                        end
                    end else begin
                        state_nxt_s = WAIT_BYTE;
                    end
                end
                CS_HOLD: begin
                    if (delay_done_i) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = CS_HOLD;
                    end
                end
                DONE:    state_nxt_s = IDLE;
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // Output decode from the next state so the registered outputs track the state register
    always_comb begin
        busy_nxt_s       = (state_nxt_s != IDLE);
        cs_n_nxt_s       = (state_nxt_s == IDLE) || (state_nxt_s == DONE);
        delay_en_nxt_s   = (state_nxt_s == CS_SETUP) || (state_nxt_s == T6) ||
                           (state_nxt_s == CS_HOLD);
        byte_start_nxt_s = (state_nxt_s == SEND_CMD) || (state_nxt_s == READ_BYTE);
        data_valid_nxt_s = (state_nxt_s == DONE);
        byte_tx_nxt_s    = byte_tx_o;
        case (state_nxt_s)
            SEND_CMD:  byte_tx_nxt_s = cmd_nxt_s;
            READ_BYTE: byte_tx_nxt_s = TX_FILL;
            default:   byte_tx_nxt_s = byte_tx_o;
        endcase
    end

    // State, latched transaction parameters and registered outputs
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r      <= IDLE;
            cmd_r        <= 8'd0;
            nrx_r        <= 2'd0;
            cnt_r        <= 2'd0;
            data_r       <= 24'd0;
            busy_o       <= 1'b0;
            cs_n_o       <= 1'b1;
            byte_start_o <= 1'b0;
            byte_tx_o    <= 8'd0;
            delay_en_o   <= 1'b0;
            data_valid_o <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            cmd_r        <= cmd_nxt_s;
            nrx_r        <= nrx_nxt_s;
            cnt_r        <= cnt_nxt_s;
            data_r       <= data_nxt_s;
            busy_o       <= busy_nxt_s;
            cs_n_o       <= cs_n_nxt_s;
            byte_start_o <= byte_start_nxt_s;
            byte_tx_o    <= byte_tx_nxt_s;
            delay_en_o   <= delay_en_nxt_s;
            data_valid_o <= data_valid_nxt_s;
        end
    end

    assign data_o = data_r;

endmodule
